// File: rtl/hazard_scoreboard_if.sv
// ID-stage to hazard-unit signal bundle: instruction decode fields in, pipeline controls out.
// The master side is the decode stage; the slave side is the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = 5
);
    logic                i_id_valid;
    logic [REG_W-1:0]    i_id_rs;
    logic [REG_W-1:0]    i_id_rt;
    logic                i_id_uses_rs;
    logic                i_id_uses_rt;
    logic                i_id_is_load;
    logic [REG_W-1:0]    i_id_dest;
    logic                i_id_is_halt;
    logic                i_take_branch;
    logic                i_mem_wait;
    logic                o_stall;
    logic                o_flush_id_ex;
    logic                o_flush_if_id;
    logic                o_halt;
    logic                o_draining;
    logic [NUM_REGS-1:0] o_busy_mask;

    modport master (
        output i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
               i_id_is_load, i_id_dest, i_id_is_halt, i_take_branch, i_mem_wait,
        input  o_stall, o_flush_id_ex, o_flush_if_id, o_halt, o_draining, o_busy_mask
    );

    modport slave (
        input  i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
               i_id_is_load, i_id_dest, i_id_is_halt, i_take_branch, i_mem_wait,
        output o_stall, o_flush_id_ex, o_flush_if_id, o_halt, o_draining, o_busy_mask
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register load scoreboard with memory-wait freeze, hazard-gated branch flush
// and a RUN -> DRAIN -> HALTED shutdown sequence.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    hazard_scoreboard_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(LOAD_LAT + 1);
    localparam int unsigned ADDR_N = 2 ** REG_W;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          drain_q, drain_d;
    logic [CNT_W-1:0]    busy_q [NUM_REGS];
    logic [CNT_W-1:0]    busy_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;
    logic [ADDR_N-1:0]   busy_ext;
    logic                run;
    logic                halt_seen;
    logic                load_hazard;
    logic                issue;
    logic                load_set;

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (busy_q[r] != '0);
        end
        // Zero-extend to the full address space so any rs/rt code indexes safely.
        busy_ext                 = '0;
        busy_ext[NUM_REGS-1:0]   = busy_vec;
        busy_ext[0]              = 1'b0;
    end

    always_comb begin
        run         = (state_q == S_RUN);
        halt_seen   = bus.i_id_valid && bus.i_id_is_halt;
        load_hazard = run && bus.i_id_valid &&
                      ((bus.i_id_uses_rs && busy_ext[bus.i_id_rs]) ||
                       (bus.i_id_uses_rt && busy_ext[bus.i_id_rt]));
        issue       = run && bus.i_id_valid && !load_hazard &&
                      !bus.i_mem_wait && !bus.i_id_is_halt;
        load_set    = issue && bus.i_id_is_load && (bus.i_id_dest != '0);
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = busy_q[r];
            if (r == 0) begin
                busy_d[r] = '0;
            end else if (!bus.i_mem_wait) begin
                // A new load to a still-counting register reloads the full latency.
                if (load_set && (REG_W'(r) == bus.i_id_dest)) begin
                    busy_d[r] = CNT_W'(LOAD_LAT);
                end else if (busy_q[r] != '0) begin
                    busy_d[r] = busy_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            S_RUN: begin
                if (halt_seen && !bus.i_mem_wait) begin
                    state_d = S_DRAIN;
                    drain_d = 4'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (!bus.i_mem_wait) begin
                    if (drain_q == '0) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_RUN;
            drain_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

    always_comb begin
        bus.o_stall       = bus.i_mem_wait || load_hazard || !run || halt_seen;
        bus.o_flush_id_ex = !bus.i_mem_wait && (load_hazard || !run || halt_seen);
        bus.o_flush_if_id = run && bus.i_take_branch && !load_hazard && !bus.i_mem_wait;
        bus.o_halt        = (state_q == S_HALTED);
        bus.o_draining    = (state_q == S_DRAIN);
        bus.o_busy_mask   = busy_vec;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized checks of hazard_scoreboard against a timestamp-based
// reference: a register is busy until LOAD_LAT unfrozen cycles have elapsed since its load.
module tb_hazard_scoreboard;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned LOAD_LAT     = 3;
    localparam int unsigned DRAIN_CYCLES = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) bus ();

    hazard_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .REG_W       (REG_W),
        .LOAD_LAT    (LOAD_LAT),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: count of unfrozen edges, per-register load timestamps, halt timestamp.
    int eff;
    bit ld_v   [NUM_REGS];
    int ld_eff [NUM_REGS];
    bit halt_v;
    int halt_eff;

    bit last_stall, last_drain, last_halt;

    function automatic bit m_busy(int r);
        return (r != 0) && (r < NUM_REGS) && ld_v[r] && ((eff - ld_eff[r]) <= int'(LOAD_LAT));
    endfunction

    function automatic int m_phase();
        if (!halt_v) return 0;
        if ((eff - halt_eff) <= int'(DRAIN_CYCLES)) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        eff    = 0;
        halt_v = 1'b0;
        halt_eff = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            ld_v[r]   = 1'b0;
            ld_eff[r] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit ld, input int dest, input bit hlt, input bit br, input bit mw);
        bus.i_id_valid    = v;
        bus.i_id_rs       = REG_W'(rs);
        bus.i_id_rt       = REG_W'(rt);
        bus.i_id_uses_rs  = urs;
        bus.i_id_uses_rt  = urt;
        bus.i_id_is_load  = ld;
        bus.i_id_dest     = REG_W'(dest);
        bus.i_id_is_halt  = hlt;
        bus.i_take_branch = br;
        bus.i_mem_wait    = mw;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Checks all outputs for the current inputs, then advances one clock and the model.
    task automatic cycle();
        int ph;
        bit run, v, hz, hv, mw, issue;
        logic [31:0] mask;
        #1;
        ph  = m_phase();
        run = (ph == 0);
        v   = bus.i_id_valid;
        mw  = bus.i_mem_wait;
        hv  = v && bus.i_id_is_halt;
        hz  = run && v && ((bus.i_id_uses_rs && m_busy(int'(bus.i_id_rs))) ||
                           (bus.i_id_uses_rt && m_busy(int'(bus.i_id_rt))));
        mask = '0;
        for (int r = 0; r < NUM_REGS; r++) mask[r] = m_busy(r);
        check("stall",       32'(bus.o_stall),       32'(mw || hz || !run || hv));
        check("flush_id_ex", 32'(bus.o_flush_id_ex), 32'(!mw && (hz || !run || hv)));
        check("flush_if_id", 32'(bus.o_flush_if_id), 32'(run && bus.i_take_branch && !hz && !mw));
        check("halt",        32'(bus.o_halt),        32'(ph == 2));
        check("draining",    32'(bus.o_draining),    32'(ph == 1));
        check("busy_mask",   32'(bus.o_busy_mask),   mask);
        last_stall = bus.o_stall;
        last_drain = bus.o_draining;
        last_halt  = bus.o_halt;
        issue = run && v && !hz && !mw && !bus.i_id_is_halt;
        @(posedge clk);
        if (issue && bus.i_id_is_load && (bus.i_id_dest != '0)) begin
            ld_v[bus.i_id_dest]   = 1'b1;
            ld_eff[bus.i_id_dest] = eff;
        end
        if (run && hv && !mw) begin
            halt_v   = 1'b1;
            halt_eff = eff;
        end
        if (!mw) eff++;
        #1;
    endtask

    initial begin : main
        int cnt;
        bit dbit;
        model_reset();
        idle();
        rst = 1'b1;
        #12;
        check("rst_stall",    32'(bus.o_stall),       32'd0);
        check("rst_flush_ex", 32'(bus.o_flush_id_ex), 32'd0);
        check("rst_halt",     32'(bus.o_halt),        32'd0);
        check("rst_mask",     32'(bus.o_busy_mask),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back dependent: LW $5 then consumer of $5 stalls LOAD_LAT cycles.
        set_in(1, 0, 5, 0, 0, 1, 5, 0, 0, 0); cycle();
        set_in(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!last_stall) break;
            cnt++;
        end
        check("dep_stall_len", 32'(cnt), 32'(LOAD_LAT));

        // Two loads in flight, consumers of each.
        set_in(1, 0, 2, 0, 0, 1, 2, 0, 0, 0); cycle();
        set_in(1, 0, 3, 0, 0, 1, 3, 0, 0, 0); cycle();
        set_in(1, 2, 0, 1, 0, 0, 0, 0, 0, 0); for (int i = 0; i < 2; i++) cycle();
        set_in(1, 0, 3, 0, 1, 0, 0, 0, 0, 0); for (int i = 0; i < 3; i++) cycle();

        // Load to $0 never makes a hazard; load with dest == busy rt reloads without stalling.
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
        set_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0); cycle();
        set_in(1, 0, 9, 0, 0, 1, 9, 0, 0, 0); cycle();
        set_in(1, 1, 9, 0, 0, 1, 9, 0, 0, 0); cycle();
        set_in(1, 9, 9, 1, 1, 0, 0, 0, 0, 0); for (int i = 0; i < 5; i++) cycle();

        // Taken branch on a busy operand waits, then flushes once released.
        set_in(1, 0, 7, 0, 0, 1, 7, 0, 0, 0); cycle();
        set_in(1, 7, 0, 1, 0, 0, 0, 0, 1, 0); for (int i = 0; i < 5; i++) cycle();

        // Memory wait freezes counters and suppresses bubbles.
        set_in(1, 0, 4, 0, 0, 1, 4, 0, 0, 0); cycle();
        idle(); cycle();
        set_in(1, 4, 0, 1, 0, 0, 0, 0, 0, 1); for (int i = 0; i < 3; i++) cycle();
        set_in(1, 4, 0, 1, 0, 0, 0, 0, 0, 0); for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic without HALT.
        for (int i = 0; i < 600; i++) begin
            dbit = ($urandom_range(0, 9) < 3);
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), !dbit && $urandom_range(0, 1), dbit,
                   $urandom_range(0, 7), 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of DRAIN.
        set_in(1, 0, 6, 0, 0, 1, 6, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        idle(); cycle();
        rst = 1'b1;
        #1;
        check("arst_draining", 32'(bus.o_draining),    32'd0);
        check("arst_halt",     32'(bus.o_halt),        32'd0);
        check("arst_stall",    32'(bus.o_stall),       32'd0);
        check("arst_flush",    32'(bus.o_flush_id_ex), 32'd0);
        check("arst_mask",     32'(bus.o_busy_mask),   32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        #1;

        // Full HALT sequence with one wait cycle at the HALT and one inside DRAIN.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 1); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        idle(); bus.i_mem_wait = 1'b1; cycle();
        idle();
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_halt) break;
            if (last_drain) cnt++;
        end
        check("drain_len", 32'(cnt), 32'(DRAIN_CYCLES + 1));
        check("halted",    32'(last_halt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            set_in(1, $urandom_range(0, 7), $urandom_range(0, 7), 1, 1, 0, 0,
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
